// File: rtl/inst_fetch_buffer_pkg.sv
// Shared definitions for the instruction fetch buffer.
// Holds the bus widths and the fetch FSM state encoding. Every file of the
// fetch buffer imports this package.
package inst_fetch_buffer_pkg;

  // Default bus widths: register/PC bus and instruction bus.
  localparam int unsigned REG_BUS_W  = 64;
  localparam int unsigned INST_BUS_W = 32;

  // Fetch FSM states.
  //   IDLE : no fetch outstanding
  //   REQ  : mem_req held, waiting for mem_gnt
  //   WAIT : granted, waiting for mem_rvalid
  //   DROP : granted but killed by a redirect, waiting to swallow the data
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'b00,
    FETCH_REQ  = 2'b01,
    FETCH_WAIT = 2'b10,
    FETCH_DROP = 2'b11
  } fetch_state_e;

endpackage : inst_fetch_buffer_pkg

// File: rtl/inst_fetch_buffer_fetch_fifo.sv
// Synchronous FIFO holding {pc, inst} pairs for the fetch buffer.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   flush_i       : empty the FIFO at the next edge (beats push/pop)
//   push_i/wdata_i: write one entry
//   pop_i         : drop the head entry
//   rdata_o       : head entry (storage is cleared to zero on reset)
//   count_o       : number of entries held
//   empty_o/full_o: occupancy flags
module fetch_fifo
  import inst_fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = REG_BUS_W + INST_BUS_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en_s;
  logic             pop_en_s;

  assign empty_o = (count_q == {CNT_W{1'b0}});
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when the head leaves the same cycle.
  assign push_en_s = push_i & (~full_o | pop_i);
  assign pop_en_s  = pop_i & ~empty_o;

  // Next-state pointers and count; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_en_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_en_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_en_s, pop_en_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer, count and storage registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_en_s && !flush_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
    end
  end

endmodule : fetch_fifo

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer between the PC generator and decode.
// Issues one fetch at a time to instruction memory (req/gnt/rvalid), queues
// returned {pc, inst} pairs and hands them to decode with valid/ready.
// A redirect flushes the queue and kills any fetch in flight.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   inst_addr, inst_ena     : fetch PC and request from the PC generator
//   redirect                : taken branch/jump resolved downstream
//   if_stall                : PC generator must hold inst_addr
//   mem_req, mem_addr       : memory request (held until mem_gnt)
//   mem_gnt, mem_rvalid,
//   mem_rdata               : memory grant and read response
//   id_valid, id_pc, id_inst: head queue entry to decode
//   id_ready                : decode consumes the head entry
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_BUS_W,
  parameter int unsigned INST_W = INST_BUS_W,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_ena,
  input  logic              redirect,
  output logic              if_stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  input  logic              id_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = ADDR_W + INST_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic              drop_q, drop_d;     // redirect seen while still in REQ

  logic              push_s;
  logic              pop_s;
  logic              issue_ok_s;
  logic [ENT_W-1:0]  fifo_rdata_s;
  logic [CNT_W-1:0]  fifo_cnt_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;

  // Issue only on the registered count: a same-cycle pop does not free a slot.
  assign issue_ok_s = inst_ena & ~redirect & (fifo_cnt_s < CNT_W'(DEPTH));
  assign if_stall   = inst_ena & ((state_q != FETCH_IDLE) | fifo_full_s | redirect);
  // Flush wins in the FIFO, so a ready during a redirect is harmless.
  assign pop_s      = id_ready & ~fifo_empty_s;

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign id_valid = ~fifo_empty_s;
  assign id_pc    = fifo_rdata_s[ENT_W-1:INST_W];
  assign id_inst  = fifo_rdata_s[INST_W-1:0];

  // Fetch FSM next-state and request logic.
  always_comb begin
    state_d    = state_q;
    pend_pc_d  = pend_pc_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;
    drop_d     = drop_q;
    push_s     = 1'b0;
    case (state_q)
      FETCH_IDLE: begin
        if (issue_ok_s) begin
          state_d    = FETCH_REQ;
          pend_pc_d  = inst_addr;
          mem_addr_d = inst_addr;
          mem_req_d  = 1'b1;
          drop_d     = 1'b0;
        end else begin
          state_d    = FETCH_IDLE;
        end
      end
      FETCH_REQ: begin
        // The request stays up until granted; a redirect only marks it dead.
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          state_d   = (drop_q || redirect) ? FETCH_DROP : FETCH_WAIT;
        end else if (redirect) begin
          drop_d    = 1'b1;
        end else begin
          drop_d    = drop_q;
        end
      end
      FETCH_WAIT: begin
        if (mem_rvalid) begin
          push_s  = ~redirect;
          state_d = FETCH_IDLE;
        end else if (redirect) begin
          state_d = FETCH_DROP;
        end else begin
          state_d = FETCH_WAIT;
        end
      end
      FETCH_DROP: begin
        if (mem_rvalid) begin
          state_d = FETCH_IDLE;
        end else begin
          state_d = FETCH_DROP;
        end
      end
      default: begin
        state_d   = FETCH_IDLE;
        mem_req_d = 1'b0;
        drop_d    = 1'b0;
      end
    endcase
  end

  // Fetch FSM and memory request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH_IDLE;
      pend_pc_q  <= {ADDR_W{1'b0}};
      mem_addr_q <= {ADDR_W{1'b0}};
      mem_req_q  <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_pc_q  <= pend_pc_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fetch_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (redirect),
    .push_i  (push_s),
    .wdata_i ({pend_pc_q, mem_rdata}),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .count_o (fifo_cnt_s),
    .empty_o (fifo_empty_s),
    .full_o  (fifo_full_s)
  );

endmodule : inst_fetch_buffer

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer: directed scenarios with literal
// expectations, then randomized traffic checked against a queue-based model.
module tb_inst_fetch_buffer;

  localparam int unsigned AW    = 64;
  localparam int unsigned IW    = 32;
  localparam int unsigned DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] inst_addr;
  logic          inst_ena;
  logic          redirect;
  logic          if_stall;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [IW-1:0] mem_rdata;
  logic          id_valid;
  logic [AW-1:0] id_pc;
  logic [IW-1:0] id_inst;
  logic          id_ready;

  int n_vec = 0;
  int n_err = 0;

  // Model: the single outstanding fetch is "none", "asking" (not yet
  // granted) or "granted"; killed marks it as squashed by a redirect.
  int            ph;
  bit            killed;
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_addr;
  logic [AW-1:0] qp[$];
  logic [IW-1:0] qi[$];

  always #5 clk = ~clk;

  inst_fetch_buffer #(.ADDR_W(AW), .INST_W(IW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_addr  (inst_addr),
    .inst_ena   (inst_ena),
    .redirect   (redirect),
    .if_stall   (if_stall),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_inst    (id_inst),
    .id_ready   (id_ready)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Advance the model over one clock edge using the inputs present at it.
  task automatic model_edge();
    int sz0;
    int ph0;
    logic [AW-1:0] dp;
    logic [IW-1:0] di;
    sz0 = qp.size();
    ph0 = ph;
    if (rst) begin
      ph = 0; killed = 1'b0; m_addr = '0;
      qp.delete(); qi.delete();
    end else begin
      if (!redirect && id_ready && sz0 > 0) begin
        dp = qp.pop_front();
        di = qi.pop_front();
      end
      if (ph0 == 2) begin
        if (mem_rvalid) begin
          if (!killed && !redirect) begin
            qp.push_back(m_pc);
            qi.push_back(mem_rdata);
          end
          ph = 0;
        end else if (redirect) begin
          killed = 1'b1;
        end
      end else if (ph0 == 1) begin
        if (redirect) killed = 1'b1;
        if (mem_gnt) ph = 2;
      end else if (inst_ena && !redirect && sz0 < DEPTH) begin
        ph = 1; killed = 1'b0; m_pc = inst_addr; m_addr = inst_addr;
      end
      if (redirect) begin
        qp.delete(); qi.delete();
      end
    end
  endtask

  // Compare all outputs against the model, then take one clock edge.
  task automatic step();
    #4;
    chk("mem_req", mem_req, (ph == 1));
    chk("mem_addr", mem_addr, m_addr);
    chk("id_valid", id_valid, (qp.size() != 0));
    if (qp.size() != 0) begin
      chk("id_pc", id_pc, qp[0]);
      chk("id_inst", id_inst, qi[0]);
    end
    chk("if_stall", if_stall, inst_ena & ((ph != 0) | (qp.size() == DEPTH) | redirect));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic [AW-1:0] a, input logic rd,
                       input logic g, input logic v, input logic [IW-1:0] d, input logic y);
    rst = r; inst_ena = e; inst_addr = a; redirect = rd;
    mem_gnt = g; mem_rvalid = v; mem_rdata = d; id_ready = y;
    step();
  endtask

  // One complete fetch: issue, gdel ungranted cycles, grant, data.
  task automatic fetch(input logic [AW-1:0] a, input int gdel, input logic [IW-1:0] d, input logic y);
    drive(1'b0, 1'b1, a, 1'b0, 1'b0, 1'b0, '0, y);
    for (int k = 0; k < gdel; k++) begin
      chk("req_hold", mem_req, 1'b1);
      chk("addr_hold", mem_addr, a);
      drive(1'b0, 1'b1, a, 1'b0, 1'b0, 1'b0, '0, y);
    end
    drive(1'b0, 1'b1, a, 1'b0, 1'b1, 1'b0, '0, y);
    drive(1'b0, 1'b1, a, 1'b0, 1'b0, 1'b1, d, y);
  endtask

  initial begin
    logic [AW-1:0] pc;
    logic r, e, rd, g, v, y;
    rst = 1'b1; inst_ena = 1'b0; inst_addr = '0; redirect = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; id_ready = 1'b0;
    ph = 0; killed = 1'b0; m_pc = '0; m_addr = '0;
    @(posedge clk);
    model_edge();
    #1;
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 64'h0);
    chk("rst_id_valid", id_valid, 1'b0);
    chk("rst_id_pc", id_pc, 64'h0);
    chk("rst_id_inst", id_inst, 32'h0);

    // Basic fetch at 0x0.
    drive(1'b0, 1'b1, 64'h0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("t1_req", mem_req, 1'b1);
    chk("t1_stall_req", if_stall, 1'b1);
    drive(1'b0, 1'b1, 64'h0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("t1_stall_wait", if_stall, 1'b1);
    drive(1'b0, 1'b1, 64'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0013, 1'b0);
    chk("t1_valid", id_valid, 1'b1);
    chk("t1_pc", id_pc, 64'h0);
    chk("t1_inst", id_inst, 32'h0000_0013);
    chk("t1_stall_idle", if_stall, 1'b0);

    // Fill the queue: 0x0 queued, fetch 0x4, then 0x8 must wait.
    fetch(64'h4, 0, 32'h0040_0093, 1'b0);
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, 64'h8, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      chk("t2_no_req", mem_req, 1'b0);
      chk("t2_stall_full", if_stall, 1'b1);
      chk("t2_head", id_pc, 64'h0);
    end
    drive(1'b0, 1'b1, 64'h8, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("t2_pop_no_req", mem_req, 1'b0);
    chk("t2_head_after_pop", id_pc, 64'h4);
    drive(1'b0, 1'b1, 64'h8, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("t2_issue8", mem_req, 1'b1);
    chk("t2_addr8", mem_addr, 64'h8);
    drive(1'b0, 1'b1, 64'h8, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b1, 64'h8, 1'b0, 1'b0, 1'b1, 32'h0080_0093, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("t2_drained", id_valid, 1'b0);

    // Grant delayed four cycles.
    fetch(64'h10, 4, 32'h1234_5678, 1'b0);
    chk("t3_pc", id_pc, 64'h10);
    chk("t3_inst", id_inst, 32'h1234_5678);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("t3_one_push", id_valid, 1'b0);

    // Redirect while waiting for data at 0x20.
    drive(1'b0, 1'b1, 64'h20, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b1, 64'h20, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("t4_dropped", id_valid, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("t4_still_empty", id_valid, 1'b0);
    fetch(64'h100, 0, 32'h0000_0093, 1'b0);
    chk("t4_new_pc", id_pc, 64'h100);
    chk("t4_new_inst", id_inst, 32'h0000_0093);

    // Redirect and rvalid together with one entry queued.
    drive(1'b0, 1'b1, 64'h200, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b1, 64'h200, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
    chk("t5_flushed", id_valid, 1'b0);
    chk("t5_no_req", mem_req, 1'b0);
    drive(1'b0, 1'b1, 64'h300, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("t5_idle_issue", mem_req, 1'b1);
    chk("t5_idle_addr", mem_addr, 64'h300);

    // Reset while in REQ, then a stray rvalid.
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("t6_req_cleared", mem_req, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h1111_1111, 1'b0);
    chk("t6_stray", id_valid, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("t6_stray_after", id_valid, 1'b0);

    // Randomized traffic with random memory latency.
    pc = 64'h1000;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      e  = ($urandom_range(0, 9) < 7);
      rd = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 2) == 0) pc = {$urandom, $urandom} & ~64'h3;
      g  = (ph == 1) && ($urandom_range(0, 9) < 4);
      v  = ((ph == 2) && ($urandom_range(0, 9) < 4)) ||
           ((ph == 0) && ($urandom_range(0, 19) == 0));
      y  = ($urandom_range(0, 9) < 6);
      drive(r, e, pc, rd, g, v, $urandom, y);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_inst_fetch_buffer
